fdiv_sched: RTL and testbench

- Shares one pipelined fdiv unit (fixed latency, no stall, no reset) between NREQ issue requesters.
- Round-robin arbitration with per-requester valid/ready handshake.
- Registers operands into fdiv and tracks in-flight ops with its own reset-able tag pipeline.
- Buffers results in a credit-protected FIFO so a stalled consumer never loses a result.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fdiv_res_fifo.sv | 54 +++++
 rtl/fdiv_sched.sv | 141 ++++++++++++++
 tb/tb_fdiv_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the fdiv scheduler: tag pipeline entries and buffered results.
package fpu_pkg;

  localparam int unsigned FDIV_LAT  = 4;
  // Wide enough for the largest supported requester count (4).
  localparam int unsigned FDIV_ID_W = 2;

  typedef struct packed {
    logic                 v;
    logic [FDIV_ID_W-1:0] id;
    logic [4:0]           addr;
  } fdiv_tag_t;

  typedef struct packed {
    logic [31:0]          data;
    logic [4:0]           addr;
    logic [FDIV_ID_W-1:0] id;
  } fdiv_res_t;

endpackage

// File: rtl/fdiv_res_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible whenever the FIFO is non-empty.
module fdiv_res_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  fdiv_res_t              i_wr_data,
  input  logic                   i_rd_en,
  output fdiv_res_t              o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fdiv_res_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_rd;
  logic            w_full;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      unique case ({i_wr_en, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst) i_wr_en |-> !w_full);

endmodule

// File: rtl/fdiv_sched.sv
// Round-robin issue of divide requests into a shared fixed-latency fdiv unit, with
// credit-protected buffering of results so a stalled consumer never drops one.
module fdiv_sched
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned LAT    = FDIV_LAT,
  parameter int unsigned FDEPTH = 8,
  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_x1,
  input  logic [NREQ*32-1:0] req_x2,
  input  logic [NREQ*5-1:0] req_addr,
  output logic [31:0]       div_x1,
  output logic [31:0]       div_x2,
  output logic              div_flagin,
  output logic [4:0]        div_addin,
  input  logic [31:0]       div_y,
  input  logic              div_flagout,
  input  logic [4:0]        div_addout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [4:0]        res_addr,
  output logic [IDW-1:0]    res_id
);

  localparam int unsigned CW = $clog2(FDEPTH + 1);

  logic [IDW-1:0]         r_ptr;
  logic [CW-1:0]          r_credit;
  logic                   w_found;
  logic [IDW-1:0]         w_gnt;
  logic [NREQ-1:0]        w_ready;
  logic                   w_issue;
  logic                   w_pop;
  logic [31:0]            r_div_x1;
  logic [31:0]            r_div_x2;
  logic [4:0]             r_div_addin;
  logic                   r_div_flagin;
  logic [FDIV_ID_W-1:0]   r_div_id;
  fdiv_tag_t              r_tag [LAT];
  fdiv_tag_t              w_tail;
  fdiv_res_t              w_wr_data;
  fdiv_res_t              w_head;
  logic                   w_empty;
  logic [$clog2(FDEPTH):0] w_count;

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!w_found && req_valid[(int'(r_ptr) + i) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = IDW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

  // Ready looks only at the registered credit, so a pop frees a slot from the next cycle.
  always_comb begin
    w_ready = '0;
    if (w_found && (r_credit != '0)) w_ready[w_gnt] = 1'b1;
  end

  assign req_ready = w_ready;
  assign w_issue   = w_found && (r_credit != '0);
  assign w_pop     = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_credit     <= CW'(FDEPTH);
      r_div_x1     <= '0;
      r_div_x2     <= '0;
      r_div_addin  <= '0;
      r_div_flagin <= 1'b0;
      r_div_id     <= '0;
    end else begin
      r_div_flagin <= w_issue;
      if (w_issue) begin
        r_ptr       <= IDW'((int'(w_gnt) + 1) % NREQ);
        r_div_x1    <= req_x1[int'(w_gnt)*32 +: 32];
        r_div_x2    <= req_x2[int'(w_gnt)*32 +: 32];
        r_div_addin <= req_addr[int'(w_gnt)*5 +: 5];
        r_div_id    <= FDIV_ID_W'(w_gnt);
      end
      unique case ({w_issue, w_pop})
        2'b10:   r_credit <= r_credit - 1'b1;
        2'b01:   r_credit <= r_credit + 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign div_x1     = r_div_x1;
  assign div_x2     = r_div_x2;
  assign div_addin  = r_div_addin;
  assign div_flagin = r_div_flagin;

  // Shadows the fdiv pipeline; fdiv itself has no reset, so only this copy is trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{v: r_div_flagin, id: r_div_id, addr: r_div_addin};
      for (int i = 1; i < int'(LAT); i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tail    = r_tag[LAT-1];
  assign w_wr_data = '{data: div_y, addr: w_tail.addr, id: w_tail.id};

  fdiv_res_fifo #(
    .DEPTH (FDEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (w_tail.v),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign res_valid = !w_empty;
  assign res_data  = w_head.data;
  assign res_addr  = w_head.addr;
  assign res_id    = w_head.id[IDW-1:0];

  a_fdiv_agree: assert property (@(posedge clk) disable iff (rst)
    w_tail.v |-> (div_flagout && (div_addout == w_tail.addr)));
  a_credit_range: assert property (@(posedge clk) disable iff (rst)
    (r_credit <= CW'(FDEPTH)) && (32'(w_count) + 32'(r_credit) <= FDEPTH));

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed and randomized checks of fdiv_sched against a queue-based scoreboard and an
// opaque fixed-latency fdiv stand-in without reset.
module tb_fdiv_sched;

  localparam int NREQ   = 2;
  localparam int LAT    = 4;
  localparam int FDEPTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_x1;
  logic [NREQ*32-1:0]  req_x2;
  logic [NREQ*5-1:0]   req_addr;
  logic [31:0]         div_x1, div_x2, div_y;
  logic                div_flagin, div_flagout;
  logic [4:0]          div_addin, div_addout;
  logic                res_valid, res_ready;
  logic [31:0]         res_data;
  logic [4:0]          res_addr;
  logic [0:0]          res_id;

  always #5 clk = ~clk;

  fdiv_sched #(.NREQ(NREQ), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x1      (req_x1),
    .req_x2      (req_x2),
    .req_addr    (req_addr),
    .div_x1      (div_x1),
    .div_x2      (div_x2),
    .div_flagin  (div_flagin),
    .div_addin   (div_addin),
    .div_y       (div_y),
    .div_flagout (div_flagout),
    .div_addout  (div_addout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_addr    (res_addr),
    .res_id      (res_id)
  );

  // Stand-in divider: exact on the directed operands, a fixed bit-mix elsewhere.
  function automatic logic [31:0] fdiv_fn(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h3F80_0000 && b == 32'h0000_0000) return 32'h7F80_0000;
    if (a == 32'h7F80_0000 && b == 32'h7F80_0000) return 32'h7FC0_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  logic [37:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= {div_flagin, div_addin, fdiv_fn(div_x1, div_x2)};
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign {div_flagout, div_addout, div_y} = fpipe[LAT-1];

  typedef struct {
    int          vis;
    logic [31:0] data;
    logic [4:0]  addr;
    int          id;
  } op_t;

  op_t         m_q[$];
  int          m_ptr, m_credit, cyc;
  bit          m_prev_iss;
  logic [31:0] m_prev_x1;
  logic [4:0]  m_prev_addr;
  int          n_asserts, n_fail, act_issues, base;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(int r, bit v, logic [31:0] a, logic [31:0] b, logic [4:0] ad);
    req_valid[r]        = v;
    req_x1[r*32 +: 32]  = a;
    req_x2[r*32 +: 32]  = b;
    req_addr[r*5 +: 5]  = ad;
  endtask

  task automatic rand_ops();
    for (int r = 0; r < NREQ; r++) begin
      req_x1[r*32 +: 32] = $urandom;
      req_x2[r*32 +: 32] = $urandom;
      req_addr[r*5 +: 5] = 5'($urandom_range(0, 31));
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rise.
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    int  g;
    bit  iss, pop, exp_valid;
    op_t op;
    @(negedge clk);
    g = -1;
    for (int i = 0; i < NREQ; i++)
      if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
    exp_ready = '0;
    if (g >= 0 && m_credit > 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("div_flagin", 32'(div_flagin), 32'(m_prev_iss));
    if (m_prev_iss) begin
      check("div_x1", div_x1, m_prev_x1);
      check("div_addin", 32'(div_addin), 32'(m_prev_addr));
    end
    exp_valid = (m_q.size() > 0) && (cyc >= m_q[0].vis);
    check("res_valid", 32'(res_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("res_data", res_data, m_q[0].data);
      check("res_addr", 32'(res_addr), 32'(m_q[0].addr));
      check("res_id", 32'(res_id), 32'(m_q[0].id));
    end
    if (|(req_valid & req_ready)) act_issues++;
    iss = (g >= 0) && (m_credit > 0);
    pop = exp_valid && res_ready;
    if (iss) begin
      op.data = fdiv_fn(req_x1[g*32 +: 32], req_x2[g*32 +: 32]);
      op.addr = req_addr[g*5 +: 5];
      op.id   = g;
      m_prev_x1   = req_x1[g*32 +: 32];
      m_prev_addr = req_addr[g*5 +: 5];
    end
    @(posedge clk);
    cyc++;
    if (pop) begin
      void'(m_q.pop_front());
      m_credit++;
    end
    if (iss) begin
      op.vis = cyc + LAT + 1;
      m_q.push_back(op);
      m_ptr = (g + 1) % NREQ;
      m_credit--;
    end
    m_prev_iss = iss;
    #1;
  endtask

  task automatic pulse_reset();
    rst       = 1'b1;
    req_valid = '0;
    m_q.delete();
    m_ptr      = 0;
    m_credit   = FDEPTH;
    m_prev_iss = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_div_flagin", 32'(div_flagin), 32'd0);
    check("rst_div_x1", div_x1, 32'd0);
    check("rst_div_x2", div_x2, 32'd0);
    check("rst_div_addin", 32'(div_addin), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_addr", 32'(res_addr), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_asserts = 0; n_fail = 0; act_issues = 0; cyc = 0;
    req_valid = '0; req_x1 = '0; req_x2 = '0; req_addr = '0; res_ready = 1'b1;
    #1;
    pulse_reset();

    // Single op: 6.0 / 2.0 should surface five edges after the issue edge.
    set_req(0, 1'b1, 32'h40C0_0000, 32'h4000_0000, 5'd5);
    step();
    req_valid = '0;
    repeat (8) step();

    // Fairness with both requesters continuously valid.
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (12) step();

    // Backpressure, then a single pop landing on a zero-credit cycle.
    res_ready = 1'b0;
    base      = act_issues;
    set_req(0, 1'b1, 32'h1234_5678, 32'h3F80_0000, 5'd3);
    repeat (20) step();
    check("bp_issue_count", 32'(act_issues - base), 32'd8);
    res_ready = 1'b1;
    step();
    check("bp_no_issue_on_pop", 32'(act_issues - base), 32'd8);
    res_ready = 1'b0;
    repeat (4) step();
    check("bp_one_more_issue", 32'(act_issues - base), 32'd9);
    req_valid = '0;
    res_ready = 1'b1;
    repeat (20) step();

    // Reset while three ops are still inside the divider.
    set_req(0, 1'b1, 32'hCAFE_0001, 32'h4000_0000, 5'd11);
    repeat (3) step();
    req_valid = '0;
    step();
    pulse_reset();
    repeat (12) step();
    res_ready = 1'b0;
    base      = act_issues;
    set_req(1, 1'b1, 32'h0BAD_F00D, 32'h4100_0000, 5'd17);
    repeat (12) step();
    check("post_rst_credit", 32'(act_issues - base), 32'(FDEPTH));
    req_valid = '0;
    res_ready = 1'b1;
    repeat (20) step();

    // Edge operands pass through untouched and stay in order.
    set_req(0, 1'b1, 32'h3F80_0000, 32'h0000_0000, 5'd7);
    set_req(1, 1'b1, 32'h7F80_0000, 32'h7F80_0000, 5'd9);
    repeat (2) step();
    req_valid = '0;
    repeat (10) step();

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      rand_ops();
      res_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (20) step();
    check("drained_credit", 32'(m_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
